// File: rtl/uart_pkg.sv
// Shared UART constants: default bit timing and the receiver/transmitter state encoding.
package uart_pkg;

    localparam int UART_D = 234;   // round(27 MHz / 115200 bit/s)
    localparam int UART_L = 8;     // counter width, must hold UART_D-1

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_WAITHI = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a single bit-period counter, framing-error
// detection, and a break guard that waits for the line to return high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int D = UART_D,
    parameter int L = UART_L
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_ferr,
    output logic       o_busy
);

    localparam logic [L-1:0] HALF_M1 = L'(D / 2 - 1);
    localparam logic [L-1:0] FULL_M1 = L'(D - 1);

    logic         w_rxs;
    logic [2:0]   r_state;
    logic [L-1:0] r_wait;
    logic [2:0]   r_bitcnt;
    logic [7:0]   r_shift;
    logic [7:0]   r_data;
    logic         r_valid;
    logic         r_ferr;

    uart_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_data),
        .o_q   (w_rxs)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_wait   <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_wait  <= '0;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in, so short low glitches are dropped.
                    if (r_wait == HALF_M1) begin
                        if (!w_rxs) begin
                            r_state  <= ST_DATA;
                            r_wait   <= '0;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_wait <= r_wait + L'(1);
                    end
                end
                ST_DATA: begin
                    if (r_wait == FULL_M1) begin
                        r_shift  <= {w_rxs, r_shift[7:1]};
                        r_wait   <= '0;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_wait <= r_wait + L'(1);
                    end
                end
                ST_STOP: begin
                    if (r_wait == FULL_M1) begin
                        r_wait <= '0;
                        if (w_rxs) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_WAITHI;
                        end
                    end else begin
                        r_wait <= r_wait + L'(1);
                    end
                end
                ST_WAITHI: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ferr  = r_ferr;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at a short bit period so the full byte sweep stays brief.
module tb_uart_rx;

    localparam int D = 16;
    localparam int L = 4;
    localparam int CLK_HALF = 500;
    localparam int CLK_PER = 2 * CLK_HALF;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ferr;
    logic       o_busy;

    uart_rx #(
        .D(D),
        .L(L)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (rx),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ferr  (o_ferr),
        .o_busy  (o_busy)
    );

    always #CLK_HALF clk = ~clk;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_valid_cyc = -1;
    logic [7:0] model_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Reference: a frame with a high stop bit yields its byte; a low stop bit yields
    // an error pulse while the output keeps the last good byte.
    task automatic push_frame(input logic [7:0] b, input bit stop);
        if (stop) begin
            model_data = b;
            q.push_back('{1'b0, b});
        end else begin
            q.push_back('{1'b1, model_data});
        end
    endtask

    task automatic send_bits(input logic [9:0] f, input int n, input int ppt);
        for (int i = 0; i < n; i++) begin
            rx = f[i];
            #(D * (1000 + ppt));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int ppt);
        push_frame(b, stop);
        send_bits({stop, b, 1'b0}, 10, ppt);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && (o_valid || o_ferr)) begin
            if (o_valid && o_ferr) begin
                check("pulse_exclusive", {30'd0, o_valid, o_ferr}, 32'd2);
            end
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_valid, o_ferr}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("pulse_kind_ferr", {31'd0, o_ferr}, {31'd0, mon_e.is_ferr});
                check("o_data", {24'd0, o_data}, {24'd0, mon_e.data});
                if (o_valid) last_valid_cyc <= cyc;
            end
        end
    end

    initial begin
        #(150_000 * CLK_PER);
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        int ppt;
        int gap;
        logic [7:0] bv;

        rst = 1'b1;
        rx = 1'b1;
        model_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_o_data", {24'd0, o_data}, 32'h00);
        check("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check("rst_o_ferr", {31'd0, o_ferr}, 32'd0);
        check("rst_o_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_rst", {31'd0, o_busy}, 32'd0);

        // Single frame 0x41 with latency measurement from the start-bit falling edge.
        t0 = cyc;
        send_frame(8'h41, 1'b1, 0);
        repeat (2) @(negedge clk);
        lat = last_valid_cyc - t0;
        check("latency_in_window", {31'd0, (lat >= 2 + D/2 + 9*D) && (lat <= 2 + D/2 + 9*D + 2)}, 32'd1);
        $display("info latency %0d cycles", lat);
        check("busy_after_41", {31'd0, o_busy}, 32'd0);

        // Start-bit glitch shorter than half a bit must be rejected.
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy", {31'd0, o_busy}, 32'd1);
        @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_back_idle", {31'd0, o_busy}, 32'd0);

        // Framing error followed by a held-low line.
        push_frame(8'hA5, 1'b0);
        send_bits({1'b0, 8'hA5, 1'b0}, 10, 0);
        rx = 1'b0;
        repeat (3 * D) @(negedge clk);
        check("ferr_busy_while_low", {31'd0, o_busy}, 32'd1);
        check("ferr_data_held", {24'd0, o_data}, 32'h41);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_idle_after_high", {31'd0, o_busy}, 32'd0);

        // Back-to-back frames without an idle gap.
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        repeat (3 * D) @(negedge clk);

        // Reset in the middle of data bit 4 of 0x3C, then a clean 0x5A.
        send_bits({1'b1, 8'h3C, 1'b0}, 5, 0);
        rx = 1'b1;
        #(D * 500);
        check("mid_frame_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_data", {24'd0, o_data}, 32'h00);
        check("async_rst_busy", {31'd0, o_busy}, 32'd0);
        check("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check("async_rst_ferr", {31'd0, o_ferr}, 32'd0);
        model_data = 8'h00;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * D) @(negedge clk);
        check("post_rst_idle", {31'd0, o_busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 0);
        repeat (3 * D) @(negedge clk);

        // Sweep of every byte with bit period jittered within +/-2 percent.
        for (int b = 0; b < 256; b++) begin
            ppt = int'($urandom_range(40)) - 20;
            gap = int'($urandom_range(2));
            bv = b[7:0];
            send_frame(bv, 1'b1, ppt);
            if (gap > 0) #(gap * D * 1000);
        end
        repeat (4 * D) @(negedge clk);
        check("all_expected_consumed", q.size(), 32'd0);
        check("final_data", {24'd0, o_data}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
